// File: rtl/commit_controller_if.sv
// Retirement bus: ROB head, store handshake and register-file write port.
// The controller sits on the master side; the ROB, memory unit and register file sit on the slave side.
interface commit_controller_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 readyIn;
  logic                 headValid;
  logic                 headReady;
  logic [1:0]           headKind;
  logic [4:0]           headDest;
  logic [31:0]          headValue;
  logic [ROB_WIDTH-1:0] headRobId;
  logic                 headMispredict;
  logic [31:0]          headTargetPc;
  logic                 storeDone;

  logic                 robPop;
  logic                 regUpdateValid;
  logic [4:0]           regUpdateDest;
  logic [31:0]          regUpdateValue;
  logic [ROB_WIDTH-1:0] regUpdateRobId;
  logic                 storeCommitValid;
  logic [ROB_WIDTH-1:0] storeCommitRobId;
  logic                 clearOut;
  logic                 redirectValid;
  logic [31:0]          redirectPc;
  logic [31:0]          commitCount;

  modport master (
    input  readyIn, headValid, headReady, headKind, headDest, headValue,
           headRobId, headMispredict, headTargetPc, storeDone,
    output robPop, regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
           storeCommitValid, storeCommitRobId, clearOut, redirectValid,
           redirectPc, commitCount
  );

  modport slave (
    output readyIn, headValid, headReady, headKind, headDest, headValue,
           headRobId, headMispredict, headTargetPc, storeDone,
    input  robPop, regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
           storeCommitValid, storeCommitRobId, clearOut, redirectValid,
           redirectPc, commitCount
  );
endinterface

// File: rtl/commit_controller.sv
// In-order retirement: zero-latency Mealy register writes/pops, registered store/flush/redirect/count.
// Backpressure: readyIn low freezes all state and masks pop/write; storeDone is held by the memory unit.
module commit_controller #(
  parameter int ROB_WIDTH = 4
) (
  input  logic               clockIn,
  input  logic               resetIn,
  commit_controller_if.master bus
);

  localparam logic [1:0] KIND_STORE  = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 store_vld;
  logic [ROB_WIDTH-1:0] store_id;
  logic                 clear;
  logic                 redirect_vld;
  logic [31:0]          redirect_pc;
  logic [31:0]          commit_count;

  logic                 store_vld_nxt;
  logic [ROB_WIDTH-1:0] store_id_nxt;
  logic                 clear_nxt;
  logic                 redirect_vld_nxt;
  logic [31:0]          redirect_pc_nxt;
  logic [31:0]          commit_count_nxt;

  logic                 pop_raw;
  logic                 write_raw;
  logic                 enable;
  logic                 head_go;

  assign head_go = bus.headValid && bus.headReady;
  // Combinational handshakes must never fire while stalled or held in reset.
  assign enable  = bus.readyIn && !resetIn;

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state        <= RUN;
      store_vld    <= 1'b0;
      store_id     <= '0;
      clear        <= 1'b0;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
      commit_count <= '0;
    end else if (bus.readyIn) begin
      state        <= state_nxt;
      store_vld    <= store_vld_nxt;
      store_id     <= store_id_nxt;
      clear        <= clear_nxt;
      redirect_vld <= redirect_vld_nxt;
      redirect_pc  <= redirect_pc_nxt;
      commit_count <= commit_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    store_vld_nxt    = store_vld;
    store_id_nxt     = store_id;
    clear_nxt        = 1'b0;
    redirect_vld_nxt = 1'b0;
    redirect_pc_nxt  = redirect_pc;
    commit_count_nxt = commit_count;
    pop_raw          = 1'b0;
    write_raw        = 1'b0;

    case (state)
      RUN: begin
        if (head_go) begin
          case (bus.headKind)
            KIND_STORE: begin
              state_nxt     = STORE_WAIT;
              store_vld_nxt = 1'b1;
              store_id_nxt  = bus.headRobId;
            end
            KIND_BRANCH: begin
              pop_raw          = 1'b1;
              commit_count_nxt = commit_count + 32'd1;
              if (bus.headMispredict) begin
                state_nxt        = FLUSH;
                clear_nxt        = 1'b1;
                redirect_vld_nxt = 1'b1;
                redirect_pc_nxt  = bus.headTargetPc;
              end
            end
            default: begin
              // Reserved kind 11 retires like a plain register write.
              pop_raw          = 1'b1;
              write_raw        = (bus.headDest != 5'd0);
              commit_count_nxt = commit_count + 32'd1;
            end
          endcase
        end
      end
      STORE_WAIT: begin
        if (bus.storeDone) begin
          pop_raw          = 1'b1;
          commit_count_nxt = commit_count + 32'd1;
          store_vld_nxt    = 1'b0;
          state_nxt        = RUN;
        end
      end
      FLUSH: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.robPop           = pop_raw && enable;
  assign bus.regUpdateValid   = write_raw && enable;
  assign bus.regUpdateDest    = bus.regUpdateValid ? bus.headDest  : 5'd0;
  assign bus.regUpdateValue   = bus.regUpdateValid ? bus.headValue : 32'd0;
  assign bus.regUpdateRobId   = bus.regUpdateValid ? bus.headRobId : '0;

  assign bus.storeCommitValid = store_vld;
  assign bus.storeCommitRobId = store_id;
  assign bus.clearOut         = clear;
  assign bus.redirectValid    = redirect_vld;
  assign bus.redirectPc       = redirect_pc;
  assign bus.commitCount      = commit_count;

endmodule
